// File: rtl/microwave_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : microwave_timer_ctrl
// Description : Microwave cook-timer controller. Four-digit BCD mm:ss
//               down-counter with keypad entry, start/stop, door interlock,
//               1 Hz decrement, heater enable and a completion beeper.
//               Optional build macro: QUICK_START_EN (quick start in IDLE,
//               +30 s on start while running).
// Revision    : 1.0 - initial release
// ============================================================================
module microwave_timer_ctrl #(
  parameter int DONE_TICKS   = 3,
  parameter int QUICK_SECS_T = 3
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       en,
  input  logic       key_valid,
  input  logic [3:0] key_data,
  input  logic       start,
  input  logic       stop,
  input  logic       door_open,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       heat,
  output logic       beep,
  output logic       zero,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SET   = 3'd1,
    S_RUN   = 3'd2,
    S_PAUSE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [3:0] c_done_ticks = 4'(DONE_TICKS);

  // Elaboration-time sanity check of the parameter ranges.
  if (DONE_TICKS < 1 || DONE_TICKS > 15 || QUICK_SECS_T < 0 || QUICK_SECS_T > 5) begin : g_param_check
    $error("microwave_timer_ctrl: DONE_TICKS or QUICK_SECS_T out of range");
  end

  state_t     r_state, w_state_nxt;
  logic [3:0] r_mt, r_mo, r_st, r_so;
  logic [3:0] w_mt_nxt, w_mo_nxt, w_st_nxt, w_so_nxt;
  logic [3:0] r_beep_cnt, w_beep_cnt_nxt;

  logic       w_key_ok;
  logic       w_zero;
  logic       w_last_sec;

  assign w_key_ok   = key_valid && (key_data <= 4'd9);
  assign w_zero     = (r_mt == 4'd0) && (r_mo == 4'd0) && (r_st == 4'd0) && (r_so == 4'd0);
  assign w_last_sec = (r_mt == 4'd0) && (r_mo == 4'd0) && (r_st == 4'd0) && (r_so == 4'd1);

`ifdef QUICK_START_EN
  localparam logic [3:0] c_quick_st = 4'(QUICK_SECS_T);

  logic [12:0] w_total;
  logic [12:0] w_add_m, w_add_s;
  logic [3:0]  w_add_mt, w_add_mo, w_add_st, w_add_so;

  // Time + 30 s, normalised to mm:ss with seconds 0..59 and saturated at 99:59.
  always_comb begin
    w_total  = 13'(r_mt) * 13'd600 + 13'(r_mo) * 13'd60
             + 13'(r_st) * 13'd10  + 13'(r_so) + 13'd30;
    w_add_m  = w_total / 13'd60;
    w_add_s  = w_total % 13'd60;
    w_add_mt = 4'(w_add_m / 13'd10);
    w_add_mo = 4'(w_add_m % 13'd10);
    w_add_st = 4'(w_add_s / 13'd10);
    w_add_so = 4'(w_add_s % 13'd10);
    if (w_total > 13'd5999) begin
      w_add_mt = 4'd9;
      w_add_mo = 4'd9;
      w_add_st = 4'd5;
      w_add_so = 4'd9;
    end
  end
`endif

  // State, digit and beep-counter registers.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      r_state    <= S_IDLE;
      r_mt       <= 4'd0;
      r_mo       <= 4'd0;
      r_st       <= 4'd0;
      r_so       <= 4'd0;
      r_beep_cnt <= 4'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_mt       <= w_mt_nxt;
      r_mo       <= w_mo_nxt;
      r_st       <= w_st_nxt;
      r_so       <= w_so_nxt;
      r_beep_cnt <= w_beep_cnt_nxt;
    end
  end

  // Next-state logic: one action per cycle, door > stop > start > key > tick.
  always_comb begin
    w_state_nxt    = r_state;
    w_mt_nxt       = r_mt;
    w_mo_nxt       = r_mo;
    w_st_nxt       = r_st;
    w_so_nxt       = r_so;
    w_beep_cnt_nxt = r_beep_cnt;

    case (r_state)
      S_IDLE: begin
        if (stop) begin
          // no effect in IDLE
        end else if (start) begin
`ifdef QUICK_START_EN
          if (!door_open) begin
            w_mt_nxt    = 4'd0;
            w_mo_nxt    = 4'd0;
            w_st_nxt    = c_quick_st;
            w_so_nxt    = 4'd0;
            w_state_nxt = S_RUN;
          end
`endif
        end else if (w_key_ok) begin
          w_mt_nxt    = r_mo;
          w_mo_nxt    = r_st;
          w_st_nxt    = r_so;
          w_so_nxt    = key_data;
          w_state_nxt = S_SET;
        end
      end

      S_SET: begin
        if (stop) begin
          w_mt_nxt    = 4'd0;
          w_mo_nxt    = 4'd0;
          w_st_nxt    = 4'd0;
          w_so_nxt    = 4'd0;
          w_state_nxt = S_IDLE;
        end else if (start) begin
          if (!w_zero && !door_open) begin
            w_state_nxt = S_RUN;
          end
        end else if (w_key_ok) begin
          w_mt_nxt = r_mo;
          w_mo_nxt = r_st;
          w_st_nxt = r_so;
          w_so_nxt = key_data;
        end
      end

      S_RUN: begin
        if (door_open || stop) begin
          w_state_nxt = S_PAUSE;
        end else if (start) begin
`ifdef QUICK_START_EN
          w_mt_nxt = w_add_mt;
          w_mo_nxt = w_add_mo;
          w_st_nxt = w_add_st;
          w_so_nxt = w_add_so;
`endif
        end else if (en) begin
          if (w_zero || w_last_sec) begin
            // Final second elapsed: clamp at 00:00 and start the beeper.
            w_mt_nxt       = 4'd0;
            w_mo_nxt       = 4'd0;
            w_st_nxt       = 4'd0;
            w_so_nxt       = 4'd0;
            w_beep_cnt_nxt = c_done_ticks;
            w_state_nxt    = S_DONE;
          end else if (r_so != 4'd0) begin
            w_so_nxt = r_so - 4'd1;
          end else begin
            w_so_nxt = 4'd9;
            if (r_st != 4'd0) begin
              w_st_nxt = r_st - 4'd1;
            end else begin
              w_st_nxt = 4'd5;
              if (r_mo != 4'd0) begin
                w_mo_nxt = r_mo - 4'd1;
              end else begin
                // min_tens is non-zero here since the time is not zero.
                w_mo_nxt = 4'd9;
                w_mt_nxt = r_mt - 4'd1;
              end
            end
          end
        end
      end

      S_PAUSE: begin
        if (stop) begin
          w_mt_nxt    = 4'd0;
          w_mo_nxt    = 4'd0;
          w_st_nxt    = 4'd0;
          w_so_nxt    = 4'd0;
          w_state_nxt = S_IDLE;
        end else if (start) begin
          if (!door_open) begin
            w_state_nxt = S_RUN;
          end
        end
      end

      S_DONE: begin
        if (stop) begin
          w_beep_cnt_nxt = 4'd0;
          w_state_nxt    = S_IDLE;
        end else if (start) begin
          // start has no effect once cooking has finished
        end else if (w_key_ok) begin
          w_mt_nxt       = 4'd0;
          w_mo_nxt       = 4'd0;
          w_st_nxt       = 4'd0;
          w_so_nxt       = key_data;
          w_beep_cnt_nxt = 4'd0;
          w_state_nxt    = S_SET;
        end else if (en) begin
          if (r_beep_cnt <= 4'd1) begin
            w_beep_cnt_nxt = 4'd0;
            w_state_nxt    = S_IDLE;
          end else begin
            w_beep_cnt_nxt = r_beep_cnt - 4'd1;
          end
        end
      end

      default: begin
        w_state_nxt    = S_IDLE;
        w_mt_nxt       = 4'd0;
        w_mo_nxt       = 4'd0;
        w_st_nxt       = 4'd0;
        w_so_nxt       = 4'd0;
        w_beep_cnt_nxt = 4'd0;
      end
    endcase
  end

  // Heater drops combinationally the moment the door opens.
  assign heat     = (r_state == S_RUN) && !door_open;
  assign beep     = (r_state == S_DONE);
  assign busy     = (r_state == S_RUN) || (r_state == S_PAUSE);
  assign zero     = w_zero;
  assign min_tens = r_mt;
  assign min_ones = r_mo;
  assign sec_tens = r_st;
  assign sec_ones = r_so;

endmodule
`default_nettype wire

// File: tb/tb_microwave_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_microwave_timer_ctrl
// Description : Scoreboard bench for microwave_timer_ctrl. Stimulus pushes
//               hand-computed expected snapshots; a monitor pops and compares
//               them on the falling clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_microwave_timer_ctrl;

  logic       clk;
  logic       clrn;
  logic       en;
  logic       key_valid;
  logic [3:0] key_data;
  logic       start;
  logic       stop;
  logic       door_open;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       heat, beep, zero, busy;

  typedef struct packed {
    logic [3:0] mt;
    logic [3:0] mo;
    logic [3:0] st;
    logic [3:0] so;
    logic       heat;
    logic       beep;
    logic       zero;
    logic       busy;
  } snap_t;

  snap_t exp_q[$];
  string name_q[$];
  int    checks   = 0;
  int    failures = 0;

  microwave_timer_ctrl #(
    .DONE_TICKS   (3),
    .QUICK_SECS_T (3)
  ) dut (
    .clk       (clk),
    .clrn      (clrn),
    .en        (en),
    .key_valid (key_valid),
    .key_data  (key_data),
    .start     (start),
    .stop      (stop),
    .door_open (door_open),
    .min_tens  (min_tens),
    .min_ones  (min_ones),
    .sec_tens  (sec_tens),
    .sec_ones  (sec_ones),
    .heat      (heat),
    .beep      (beep),
    .zero      (zero),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compare the DUT outputs against the oldest pending expectation.
  always @(negedge clk) begin
    snap_t e, a;
    string n;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      a = '{min_tens, min_ones, sec_tens, sec_ones, heat, beep, zero, busy};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL %s: got %h%h:%h%h heat=%b beep=%b zero=%b busy=%b, want %h%h:%h%h heat=%b beep=%b zero=%b busy=%b",
                 n, a.mt, a.mo, a.st, a.so, a.heat, a.beep, a.zero, a.busy,
                 e.mt, e.mo, e.st, e.so, e.heat, e.beep, e.zero, e.busy);
      end
    end
  end

  // Queue an expectation and wait (bounded) for the monitor to consume it.
  task automatic chk(input string n, input logic [15:0] t,
                     input logic h, input logic b, input logic z, input logic bz);
    exp_q.push_back('{t[15:12], t[11:8], t[7:4], t[3:0], h, b, z, bz});
    name_q.push_back(n);
    for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s: monitor timeout, pending=%0d, want 0", n, exp_q.size());
      exp_q.delete();
      name_q.delete();
    end
  endtask

  // One-cycle pulse of the given inputs, captured by a single rising edge.
  task automatic act(input logic kv, input logic [3:0] kd,
                     input logic s, input logic p, input logic e);
    @(posedge clk); #1;
    key_valid = kv; key_data = kd; start = s; stop = p; en = e;
    @(posedge clk); #1;
    key_valid = 1'b0; key_data = 4'd0; start = 1'b0; stop = 1'b0; en = 1'b0;
  endtask

  task automatic key(input logic [3:0] d);   act(1'b1, d, 1'b0, 1'b0, 1'b0); endtask
  task automatic do_start();                 act(1'b0, 4'd0, 1'b1, 1'b0, 1'b0); endtask
  task automatic do_stop();                  act(1'b0, 4'd0, 1'b0, 1'b1, 1'b0); endtask
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) act(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    clrn = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    clrn = 1'b0; en = 1'b0; key_valid = 1'b0; key_data = 4'd0;
    start = 1'b0; stop = 1'b0; door_open = 1'b0;

    do_reset();
    chk("reset", 16'h0000, 0, 0, 1, 0);
    clrn = 1'b1;

    // 01:30 entered, then three seconds elapse
    key(4'd1); key(4'd3); key(4'd0);
    chk("entry_0130", 16'h0130, 0, 0, 0, 0);
    do_start();
    chk("run_0130", 16'h0130, 1, 0, 0, 1);
    tick(3);
    chk("run_0127", 16'h0127, 1, 0, 0, 1);
    do_stop();
    chk("stop_pause", 16'h0127, 0, 0, 0, 1);
    do_stop();
    chk("stop_idle", 16'h0000, 0, 0, 1, 0);

    // 00:02 runs out, beeper held for three ticks
    key(4'd0); key(4'd2); do_start(); tick(2);
    chk("done", 16'h0000, 0, 1, 1, 0);
    tick(2);
    chk("done_beep2", 16'h0000, 0, 1, 1, 0);
    tick(1);
    chk("done_idle", 16'h0000, 0, 0, 1, 0);

    // Borrow chains
    key(4'd1); key(4'd0); key(4'd0); do_start(); tick(1);
    chk("borrow_0059", 16'h0059, 1, 0, 0, 1);
    do_stop(); do_stop();
    key(4'd1); key(4'd0); key(4'd0); key(4'd0); do_start(); tick(1);
    chk("borrow_0959", 16'h0959, 1, 0, 0, 1);
    do_stop(); do_stop();

    // Door interlock while running at 00:45
    key(4'd4); key(4'd5); do_start();
    chk("run_0045", 16'h0045, 1, 0, 0, 1);
    @(posedge clk); #1;
    door_open = 1'b1;
    chk("door_heat_same_cycle", 16'h0045, 0, 0, 0, 1);
    tick(3);
    chk("pause_held", 16'h0045, 0, 0, 0, 1);
    do_start();
    chk("start_door_open_ign", 16'h0045, 0, 0, 0, 1);
    door_open = 1'b0;
    do_start();
    chk("resume_0045", 16'h0045, 1, 0, 0, 1);
    tick(1);
    chk("resume_0044", 16'h0044, 1, 0, 0, 1);
    do_stop(); do_stop();

    // Invalid key, start+stop together
    key(4'd7); key(4'hC);
    chk("key_c_ignored", 16'h0007, 0, 0, 0, 0);
    act(1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
    chk("stop_beats_start", 16'h0000, 0, 0, 1, 0);

    // Oldest digit is shifted out
    key(4'd1); key(4'd2); key(4'd3); key(4'd4); key(4'd5);
    chk("shift_2345", 16'h2345, 0, 0, 0, 0);
    do_stop();

    // Zero time in SET cannot start
    key(4'd0); do_start();
    chk("set_zero_no_start", 16'h0000, 0, 0, 1, 0);
    do_stop();

    // sec_tens above 5 counts down normally; reset mid-run
    key(4'd9); key(4'd0); do_start(); tick(1);
    chk("count_0089", 16'h0089, 1, 0, 0, 1);
    do_reset();
    chk("reset_mid_run", 16'h0000, 0, 0, 1, 0);
    clrn = 1'b1;

    // Key during DONE restarts entry
    key(4'd0); key(4'd1); do_start(); tick(1);
    chk("done_from_0001", 16'h0000, 0, 1, 1, 0);
    key(4'd3);
    chk("done_key_set", 16'h0003, 0, 0, 0, 0);
    do_stop();

`ifdef QUICK_START_EN
    do_start();
    chk("quick_start", 16'h0030, 1, 0, 0, 1);
    do_stop(); do_stop();
    key(4'd9); key(4'd9); key(4'd4); key(4'd5); do_start();
    do_start();
    chk("add30_saturate", 16'h9959, 1, 0, 0, 1);
`else
    do_start();
    chk("idle_start_ignored", 16'h0000, 0, 0, 1, 0);
    key(4'd9); key(4'd9); key(4'd4); key(4'd5); do_start();
    do_start();
    chk("run_start_ignored", 16'h9945, 1, 0, 0, 1);
`endif
    do_stop(); do_stop();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/microwave_timer_ctrl.md
Name: microwave_timer_ctrl

Overview:
Controller that sequences the microwave cook timer as a 4-digit BCD mm:ss down-counter. Accepts keypad digits, start/stop and door-interlock inputs, and decrements the time on the 1 Hz tick. Drives the heater enable, the completion beeper and the display digits. Sits between the keypad decoder/tick prescaler and the display/magnetron drivers.

Parameters:
DONE_TICKS, 3, number of `en` ticks the beeper stays on in DONE (1..15)
QUICK_SECS_T, 3, seconds-tens digit loaded by quick start (optional feature only)

Ports:
clk  input  1  system clock, all state updates on rising edge
clrn  input  1  synchronous active-low reset
en  input  1  1 Hz tick, single-cycle pulse
key_valid  input  1  keypad digit strobe, single-cycle pulse
key_data  input  4  keypad digit, BCD
start  input  1  start pulse
stop  input  1  stop/clear pulse
door_open  input  1  door interlock, level
min_tens  output  4  minutes tens digit
min_ones  output  4  minutes ones digit
sec_tens  output  4  seconds tens digit
sec_ones  output  4  seconds ones digit
heat  output  1  magnetron enable
beep  output  1  completion beeper
zero  output  1  all four digits are 0
busy  output  1  state is RUN or PAUSE

Behaviour:
- Reset (clrn low at rising clk): state IDLE, all digits 0, beep counter 0; beep=0, zero=1, busy=0, heat=0.
- States: IDLE, SET, RUN, PAUSE, DONE. Registered; digits and beep counter registered.
- heat = (state==RUN) & ~door_open, combinational: drops in the same cycle the door opens.
- zero, busy: combinational from registers. beep = (state==DONE).
- Per-cycle priority: door_open > stop > start > key_valid > en. At most one action per cycle; lower-priority inputs in that cycle are dropped.
- key_valid with key_data > 9: ignored in every state.
- IDLE: valid key -> SET, digits shift left (min_tens<=min_ones, min_ones<=sec_tens, sec_tens<=sec_ones, sec_ones<=key). start ignored when zero (see optional feature). stop: no effect.
- SET: valid key -> shift as above (oldest digit lost). start with zero=0 and door closed -> RUN. start with zero=1 -> stay in SET. stop -> IDLE, digits cleared.
- RUN: door_open -> PAUSE. stop -> PAUSE. Keys and start ignored. en -> decrement by one second:
  sec_ones>0: sec_ones-1.
  sec_ones==0: sec_ones<=9; borrow to sec_tens.
  sec_tens borrow at 0: sec_tens<=5; borrow to min_ones.
  min_ones borrow at 0: min_ones<=9; min_tens-1.
  sec_tens may hold 6..9 from keypad entry (e.g. 00:90); it counts down normally, and only reloads 5 on borrow.
  If the value before the decrement is 00:01 -> digits become 00:00 and state -> DONE, beep counter loaded with DONE_TICKS.
- PAUSE: start with door closed -> RUN, digits retained. start with door open -> ignored. stop -> IDLE, digits cleared. Keys ignored. en ignored.
- DONE: each en decrements the beep counter. Reaching 0 -> IDLE. stop -> IDLE immediately. Valid key -> SET with that digit in sec_ones and the other digits 0; beep ends.
- door_open in IDLE/SET/DONE: blocks start only; no state change.
- Time never underflows below 00:00. All digits always remain in 0..9.

Optional Feature:
QUICK_START_EN:
- Defined: start in IDLE with door closed loads 00:(QUICK_SECS_T)0 and enters RUN in the same action. start in RUN adds 30 s to the time, saturating at 99:59, with carries in BCD (seconds 0..59 carry into minutes).
- Undefined: start in IDLE is ignored; start in RUN is ignored.

Test Plan:
- Reset, then keys 1,3,0; start; 3 en pulses -> digits 01:27, heat=1, busy=1.
- Load 00:02; start; 2 en pulses -> DONE, beep=1, zero=1, heat=0. After DONE_TICKS (3) further en pulses -> IDLE, beep=0.
- Load 01:00; start; 1 en pulse -> 00:59 (borrow chain). Load 10:00; 1 en pulse -> 09:59.
- RUN at 00:45; raise door_open -> heat=0 in the same cycle, PAUSE. en pulses -> time held at 00:45. Close door, start -> RUN resumes from 00:45.
- SET state: key 0xC ignored. Simultaneous start+stop -> stop wins, IDLE with 00:00. clrn low mid-RUN -> IDLE, 00:00 on the next edge.
- With QUICK_START_EN: start in IDLE -> 00:30, RUN. start at 99:45 -> 99:59. Without the macro: start in IDLE -> remains IDLE.
